mux_scan_ctrl: RTL and testbench
================================

MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

Interface
REQ-001 The block SHALL have parameter N, default 16, meaning the number of mux channels scanned per frame.
REQ-002 The block SHALL have parameter SEL_W, default 4, meaning the select width, with N == 2**SEL_W.
REQ-003 The block SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, meaning reset, asynchronous and active-high.
REQ-005 The block SHALL have port start, input, 1, meaning a request to scan one frame, sampled at the clk edge.
REQ-006 The block SHALL have port mux_out, input, 1, meaning the combinational output of the downstream N:1 mux.
REQ-007 The block SHALL have port sel, output, [0:SEL_W-1], meaning the registered channel select driven to the mux.
REQ-008 The block SHALL have port busy, output, 1, meaning a scan is in progress.
REQ-009 The block SHALL have port done, output, 1, meaning a one-cycle pulse when a frame is complete.
REQ-010 The block SHALL have port data, output, [0:N-1], meaning the last completed frame, with data[k] = value of mux input k.
REQ-011 The block SHALL have port parity, output, 1, meaning even parity of data, present only with PARITY_EN.

Function
REQ-012 The block SHALL implement states IDLE, SCAN and DONE.
REQ-013 In IDLE, start=1 at an edge SHALL move to SCAN with sel<=0 and busy<=1; start=0 keeps IDLE.
REQ-014 In SCAN, each edge SHALL shift mux_out into an internal N-bit register as sh <= {sh[1:N-1], mux_out} and set sel<=sel+1.
REQ-015 The sample at each SCAN edge SHALL belong to the channel currently on sel, so the mux path has one full cycle to settle.
REQ-016 At the SCAN edge where sel==N-1, the block SHALL load data <= {sh[1:N-1], mux_out}, wrap sel to 0, clear busy, set done, and go to DONE.
REQ-017 A frame SHALL therefore take exactly N SCAN edges, with done high in the cycle after the N-th sample.
REQ-018 DONE SHALL last exactly one cycle, clear done, and return to IDLE unconditionally.
REQ-019 A start in DONE SHALL be ignored; a new frame needs start in IDLE, so the minimum start-to-start spacing is N+2 cycles.
REQ-020 A start in SCAN SHALL be ignored and SHALL NOT restart or extend the frame.
REQ-021 data SHALL change only at REQ-016 and hold its value through later scans until the next frame completes.
REQ-022 sel SHALL hold 0 in IDLE and DONE.

Reset
REQ-023 Asserting rst SHALL immediately force state IDLE, sel=0, busy=0, done=0, data=0, internal shift register=0, and parity=0.
REQ-024 A reset during SCAN SHALL abandon the partial frame with no done pulse, and data SHALL read 0.
REQ-025 After rst deasserts, the first start SHALL be honoured at the first rising edge.

Configuration
REQ-026 With macro MUX_SCAN_PARITY_EN defined, the block SHALL provide the parity port, registered together with data, equal to the XOR of the loaded word.
REQ-027 Without MUX_SCAN_PARITY_EN, the parity port and its logic SHALL be absent, and all other behaviour SHALL be unchanged.

Verification
REQ-028 Reset then a start pulse with the mux inputs = 16'b1000000000000000 -> sel steps 0..15 over 16 cycles, then done=1 for one cycle and data=16'b1000000000000000.
REQ-029 Walking one with the mux inputs = 16'b0000000000000001 -> data=16'b0000000000000001, and busy is high for exactly 16 cycles.
REQ-030 Mux inputs = 16'hA5C3, then after completion the inputs change to 16'hFFFF with no start -> data stays 16'hA5C3; with the macro, parity=0.
REQ-031 start held high continuously -> a done pulse every 18 cycles, and start during SCAN or DONE has no effect.
REQ-032 rst asserted at sel=7 mid-scan -> all outputs are 0 immediately, no done pulse follows, and the next start produces a full 16-cycle frame.
REQ-033 With the macro defined and the mux inputs = 16'h0001 -> parity=1 in the same cycle that done=1.

Source files
------------

// File: rtl/mux_scan_ctrl.sv
// Sequential scanner for an external N:1 mux: steps the select across all channels,
// assembles one frame per start request. Optional even-parity output via MUX_SCAN_PARITY_EN.
module mux_scan_ctrl #(
    parameter int N     = 16,
    parameter int SEL_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mux_out,
    output logic [0:SEL_W-1] sel,
    output logic             busy,
    output logic             done,
    output logic [0:N-1]     data
`ifdef MUX_SCAN_PARITY_EN
    ,
    output logic             parity
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [0:SEL_W-1] sel_q, sel_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [0:N-1]     sh_q, sh_d;
    logic [0:N-1]     data_q, data_d;
    logic             last_ch;
    logic [0:N-1]     frame_word;

    // The sample taken at this edge belongs to the channel currently on sel,
    // so the word completing on the last channel is the shift result itself.
    assign last_ch    = (sel_q == SEL_W'(N - 1));
    assign frame_word = {sh_q[1:N-1], mux_out};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sh_q    <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sh_q    <= sh_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SCAN;
            SCAN:    if (last_ch) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sel_d  = sel_q;
        busy_d = busy_q;
        done_d = 1'b0;
        sh_d   = sh_q;
        data_d = data_q;
        case (state_q)
            IDLE: begin
                sel_d  = '0;
                busy_d = start;
            end
            SCAN: begin
                sh_d  = frame_word;
                sel_d = sel_q + SEL_W'(1);
                if (last_ch) begin
                    data_d = frame_word;
                    sel_d  = '0;
                    busy_d = 1'b0;
                    done_d = 1'b1;
                end
            end
            DONE: begin
                sel_d  = '0;
                busy_d = 1'b0;
            end
            default: begin
                sel_d  = '0;
                busy_d = 1'b0;
            end
        endcase
    end

`ifdef MUX_SCAN_PARITY_EN
    logic parity_q, parity_d;

    always_comb begin
        parity_d = parity_q;
        if (state_q == SCAN && last_ch) parity_d = ^frame_word;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) parity_q <= 1'b0;
        else     parity_q <= parity_d;
    end

    assign parity = parity_q;
`endif

    assign sel  = sel_q;
    assign busy = busy_q;
    assign done = done_q;
    assign data = data_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Self-checking bench for mux_scan_ctrl: directed frames, randomized frames with
// stray start requests, back-to-back starts and mid-scan reset.
module tb_mux_scan_ctrl;

    localparam int N     = 16;
    localparam int SEL_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             mux_out;
    logic [0:SEL_W-1] sel;
    logic             busy;
    logic             done;
    logic [0:N-1]     data;
    logic [0:N-1]     mux_in;
`ifdef MUX_SCAN_PARITY_EN
    logic             parity;
`endif

    int checks = 0;
    int errors = 0;

    mux_scan_ctrl #(.N(N), .SEL_W(SEL_W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .mux_out(mux_out),
        .sel    (sel),
        .busy   (busy),
        .done   (done),
        .data   (data)
`ifdef MUX_SCAN_PARITY_EN
        ,
        .parity (parity)
`endif
    );

    always #5 clk = ~clk;

    // The downstream mux: channel k presents mux_in[k].
    assign mux_out = mux_in[sel];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_sel"}, 64'(sel), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_data"}, 64'(data), 64'd0);
`ifdef MUX_SCAN_PARITY_EN
        chk({tag, "_parity"}, 64'(parity), 64'd0);
`endif
    endtask

    // One full frame from IDLE: sel walks 0..N-1, busy for N cycles, then one done cycle.
    task automatic run_frame(input logic [0:N-1] pat, input bit noisy);
        int busy_cycles;
        busy_cycles = 0;
        mux_in = pat;
        start  = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < N; i++) begin
            chk($sformatf("scan_sel%0d", i), 64'(sel), 64'(i));
            chk($sformatf("scan_done%0d", i), 64'(done), 64'd0);
            if (busy) busy_cycles++;
            if (noisy) start = 1'($urandom_range(0, 1));
            step();
        end
        start = noisy ? 1'b1 : 1'b0;
        chk("busy_cycles", 64'(busy_cycles), 64'(N));
        chk("frame_done", 64'(done), 64'd1);
        chk("frame_busy_low", 64'(busy), 64'd0);
        chk("frame_sel_wrap", 64'(sel), 64'd0);
        chk("frame_data", 64'(data), 64'(pat));
`ifdef MUX_SCAN_PARITY_EN
        chk("frame_parity", 64'(parity), 64'(^pat));
`endif
        step();
        start = 1'b0;
        chk("after_done_done", 64'(done), 64'd0);
        chk("after_done_busy", 64'(busy), 64'd0);
        chk("after_done_sel", 64'(sel), 64'd0);
        $display("frame pattern=%h data=%h noisy=%0d", pat, data, noisy);
    endtask

    initial begin
        logic [0:N-1] pat;
        logic [0:N-1] cur_pat;
        int           p;

        rst    = 1'b1;
        start  = 1'b0;
        mux_in = '0;
        #2;
        chk_zero("reset");
        step();
        #3 rst = 1'b0;

        run_frame(16'b1000000000000000, 1'b0);
        run_frame(16'b0000000000000001, 1'b0);
        run_frame(16'hA5C3, 1'b0);

        // Inputs change with no start: data must hold.
        mux_in = 16'hFFFF;
        repeat (5) step();
        chk("hold_data", 64'(data), 64'hA5C3);
        chk("hold_busy", 64'(busy), 64'd0);
`ifdef MUX_SCAN_PARITY_EN
        chk("hold_parity", 64'(parity), 64'd0);
`endif

        for (int r = 0; r < 6; r++) begin
            pat = N'($urandom);
            run_frame(pat, r[0]);
        end

        // start held high: frames begin at edges 0, 18, 36; start drops before edge 54.
        cur_pat = N'($urandom);
        mux_in  = cur_pat;
        for (int t = 0; t < 60; t++) begin
            start = (t < 54) ? 1'b1 : 1'b0;
            step();
            p = t % 18;
            if (t >= 54) begin
                chk($sformatf("cont_idle_busy_t%0d", t), 64'(busy), 64'd0);
                chk($sformatf("cont_idle_done_t%0d", t), 64'(done), 64'd0);
            end else begin
                chk($sformatf("cont_busy_t%0d", t), 64'(busy), 64'(p < 16));
                chk($sformatf("cont_done_t%0d", t), 64'(done), 64'(p == 16));
                chk($sformatf("cont_sel_t%0d", t), 64'(sel), 64'((p < 16) ? p : 0));
                if (p == 16) begin
                    chk($sformatf("cont_data_t%0d", t), 64'(data), 64'(cur_pat));
                    $display("continuous done at edge %0d data=%h", t, data);
                end
                if (p == 17) begin
                    cur_pat = N'($urandom);
                    mux_in  = cur_pat;
                end
            end
        end
        start = 1'b0;

        // Reset in the middle of a scan at sel=7.
        mux_in = N'($urandom);
        start  = 1'b1;
        step();
        start = 1'b0;
        repeat (7) step();
        chk("pre_reset_sel", 64'(sel), 64'd7);
        #2 rst = 1'b1;
        #1;
        chk_zero("midscan_reset");
        $display("mid-scan reset applied at sel=7");
        step();
        #3 rst = 1'b0;
        for (int t = 0; t < 20; t++) begin
            step();
            chk($sformatf("no_done_t%0d", t), 64'(done), 64'd0);
            chk($sformatf("no_busy_t%0d", t), 64'(busy), 64'd0);
        end
        chk("post_reset_data", 64'(data), 64'd0);

        // Start honoured at the very first edge after reset release.
        #2 rst = 1'b1;
        #3 rst = 1'b0;
        run_frame(N'($urandom), 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
